rxd_frame_check: RTL and testbench
==================================

# rxd_frame_check

Parametrised serial receive-frame checker for the IrDA/UART receive path, sitting behind the bit-sampling stage. It consumes one sampled line bit per strobe, assembles start/data/parity/stop fields, and emits the data word with parity, framing and break status. It adds two things the per-word combinational checker lacked: configurable frame format and saturating error counters.

## Interface
Parameters:
- DATA_W, 8, data bits per frame, legal 5..9, LSB transmitted first
- PARITY_MODE, 1, 0 = no parity bit, 1 = even, 2 = odd
- STOP_BITS, 1, stop bits per frame, legal 1 or 2
- CNT_W, 8, width of each error counter

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; forces every register to its reset value
- rx_en  input  1  receiver enable; low holds FSM in IDLE
- bit_stb  input  1  one-cycle strobe, bit_in valid this cycle
- bit_in  input  1  sampled line bit (idle = 1)
- parity_check  input  1  runtime parity-check enable, sampled on the final stop-bit strobe
- clr_cnt  input  1  synchronous clear of both counters
- data_out  output  DATA_W  last received word, held until next frame completes
- data_valid  output  1  one-cycle pulse, frame complete
- parity_error  output  1  valid with data_valid
- framing_error  output  1  valid with data_valid
- break_det  output  1  valid with data_valid
- busy  output  1  high while FSM is not IDLE
- parity_err_cnt  output  CNT_W  saturating parity-error count
- framing_err_cnt  output  CNT_W  saturating framing-error count

## Operation
- FSM states: IDLE, DATA, PARITY, STOP. Only bit_stb cycles advance it.
- IDLE: strobe with bit_in=0 -> DATA, bit counter 0; strobe with bit_in=1 -> stay.
- DATA: shift bit_in into position bit counter (LSB first); after DATA_W strobes -> PARITY if PARITY_MODE != 0, else STOP.
- PARITY: one strobe captures parity bit -> STOP.
- STOP: STOP_BITS strobes. Any stop bit = 0 flags framing error; with 2 stop bits a bad first stop bit does not abort, the second is still consumed. After the last stop strobe -> IDLE.
- Parity error: parity_check=1, PARITY_MODE=1 and (parity bit XOR reduction-XOR of data) = 1; PARITY_MODE=2 and that value = 0. Forced 0 if parity_check=0 or PARITY_MODE=0; the parity bit is still consumed.
- Break: data all 0, parity bit 0 (if present), all stop bits 0 -> break_det=1; framing_error is also 1.
- Counters: increment by 1 on each data_valid with the matching flag; hold at 2^CNT_W-1. clr_cnt has priority over an increment in the same cycle (result 0).
- rx_en=0: FSM returns to IDLE on the next edge; a partial frame is discarded with no data_valid; data_out and counters hold.
- Reset: all outputs 0, FSM IDLE, counters 0.

## Timing
- All outputs registered.
- data_valid, data_out, parity_error, framing_error and break_det update on the edge that samples the final stop-bit strobe, and are visible the following cycle.
- data_valid is high for exactly one cycle. The flags hold their values until the next data_valid.
- Counters update on the same edge as data_valid.
- busy rises on the edge sampling the start bit and falls on the edge sampling the last stop bit.
- Back-to-back frames: a start bit on the strobe immediately after the last stop strobe is accepted. bit_stb may be high on consecutive cycles; no minimum spacing.
- Reset asserted mid-frame: immediate return to IDLE with no data_valid.

## Test plan
- Default params, frame 0,0x5A LSB-first,parity 0,stop 1 -> data_out=0x5A, data_valid one cycle, parity_error=0, framing_error=0, break_det=0.
- Same frame with parity bit 1 and parity_check=1 -> parity_error=1, parity_err_cnt=1. Repeat with parity_check=0 -> parity_error=0, count unchanged.
- PARITY_MODE=2, STOP_BITS=2, DATA_W=7, data 0x41, parity 1, stops 1,0 -> parity_error=0, framing_error=1, framing_err_cnt=1.
- Line held 0 for a full frame -> data_out=0x00, framing_error=1, break_det=1.
- Drive CNT_W=2 to 5 framing errors -> count saturates at 3; clr_cnt on the same cycle as the 6th error -> 0.
- Reset or rx_en=0 after 4 data bits, then a clean frame 0xA5 -> no pulse for the aborted frame; a single data_valid with 0xA5.

Source files
------------

// File: rtl/rxd_frame_check_if.sv
// Receive-frame checker bus: strobed line-bit inputs and controls in, word/status/counters out.
// No backpressure; the checker owns the outputs, the bit sampler owns the inputs.
interface rxd_frame_check_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              rx_en;
  logic              bit_stb;
  logic              bit_in;
  logic              parity_check;
  logic              clr_cnt;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_error;
  logic              framing_error;
  logic              break_det;
  logic              busy;
  logic [CNT_W-1:0]  parity_err_cnt;
  logic [CNT_W-1:0]  framing_err_cnt;

  modport master (
    output rx_en, bit_stb, bit_in, parity_check, clr_cnt,
    input  data_out, data_valid, parity_error, framing_error, break_det, busy,
    input  parity_err_cnt, framing_err_cnt
  );

  modport slave (
    input  rx_en, bit_stb, bit_in, parity_check, clr_cnt,
    output data_out, data_valid, parity_error, framing_error, break_det, busy,
    output parity_err_cnt, framing_err_cnt
  );
endinterface

// File: rtl/rxd_frame_check.sv
// Serial receive-frame checker: start/data/parity/stop assembly with parity, framing, break and error counts.
// Results registered on the edge sampling the final stop strobe; no backpressure, one bit per strobe.
module rxd_frame_check #(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            reset,
  rxd_frame_check_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [3:0]       LAST_BIT  = 4'(DATA_W - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t            state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              stop_bad_q, stop_bad_d;
  logic              stop_one_q, stop_one_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              brk_q, brk_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  pcnt_q, pcnt_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;

  logic par_mis;
  logic perr_calc;
  logic ferr_calc;
  logic brk_calc;

  // Evaluated only on the final stop strobe, when shift_q holds the whole word.
  assign par_mis   = par_q ^ (^shift_q);
  assign perr_calc = bus.parity_check &&
                     (((PARITY_MODE == 1) && par_mis) || ((PARITY_MODE == 2) && !par_mis));
  assign ferr_calc = stop_bad_q | ~bus.bit_in;
  assign brk_calc  = (shift_q == '0) && ((PARITY_MODE == 0) || !par_q) &&
                     !stop_one_q && !bus.bit_in;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    stop_cnt_d = stop_cnt_q;
    stop_bad_d = stop_bad_q;
    stop_one_d = stop_one_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;

    if (!bus.rx_en) begin
      state_d = S_IDLE;
    end else if (bus.bit_stb) begin
      case (state_q)
        S_IDLE: begin
          if (!bus.bit_in) begin
            state_d    = S_DATA;
            bit_cnt_d  = 4'd0;
            par_d      = 1'b0;
            stop_cnt_d = 1'b0;
            stop_bad_d = 1'b0;
            stop_one_d = 1'b0;
          end
        end
        S_DATA: begin
          // LSB arrives first, so shifting in from the top leaves it at bit 0.
          shift_d   = {bus.bit_in, shift_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_BIT) begin
            if (PARITY_MODE != 0) state_d = S_PARITY;
            else                  state_d = S_STOP;
          end
        end
        S_PARITY: begin
          par_d   = bus.bit_in;
          state_d = S_STOP;
        end
        S_STOP: begin
          stop_bad_d = stop_bad_q | ~bus.bit_in;
          stop_one_d = stop_one_q | bus.bit_in;
          stop_cnt_d = stop_cnt_q + 1'b1;
          if (stop_cnt_q == LAST_STOP) begin
            state_d = S_IDLE;
            valid_d = 1'b1;
            data_d  = shift_q;
            perr_d  = perr_calc;
            ferr_d  = ferr_calc;
            brk_d   = brk_calc;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    pcnt_d = pcnt_q;
    fcnt_d = fcnt_q;
    if (bus.clr_cnt) begin
      pcnt_d = '0;
      fcnt_d = '0;
    end else if (valid_d) begin
      if (perr_d && (pcnt_q != CNT_MAX)) pcnt_d = pcnt_q + 1'b1;
      if (ferr_d && (fcnt_q != CNT_MAX)) fcnt_d = fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      stop_cnt_q <= 1'b0;
      stop_bad_q <= 1'b0;
      stop_one_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      busy_q     <= 1'b0;
      pcnt_q     <= '0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      stop_cnt_q <= stop_cnt_d;
      stop_bad_q <= stop_bad_d;
      stop_one_q <= stop_one_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      busy_q     <= busy_d;
      pcnt_q     <= pcnt_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign bus.data_out        = data_q;
  assign bus.data_valid      = valid_q;
  assign bus.parity_error    = perr_q;
  assign bus.framing_error   = ferr_q;
  assign bus.break_det       = brk_q;
  assign bus.busy            = busy_q;
  assign bus.parity_err_cnt  = pcnt_q;
  assign bus.framing_err_cnt = fcnt_q;
endmodule

// File: tb/tb_rxd_frame_check.sv
// Bench for rxd_frame_check: three parameterisations driven with directed and random frames,
// compared against a field-level frame model with saturating counters.
module tb_rxd_frame_check;
  localparam int NI = 3;
  localparam int DWV [NI] = '{8, 7, 8};
  localparam int PMV [NI] = '{1, 2, 0};
  localparam int SBV [NI] = '{1, 2, 1};
  localparam int CWV [NI] = '{8, 8, 2};

  typedef struct packed {
    logic [1:0] k;
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
    logic       dbl;
    logic [7:0] pc;
    logic [7:0] fc;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  logic [NI-1:0] en, stb, bin, pchk, clr;
  wire  [NI-1:0][8:0] dout;
  wire  [NI-1:0] dv, pe, fe, brk, busy;
  wire  [NI-1:0][7:0] pcnt, fcnt;
  logic [NI-1:0] prev_dv = '0;

  int total = 0;
  int bad = 0;
  rec_t got_q[$];
  rec_t exp_q[$];
  int mp [NI];
  int mf [NI];
  logic [8:0] last_d [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    rxd_frame_check_if #(.DATA_W(DWV[g]), .CNT_W(CWV[g])) bus ();
    assign bus.rx_en        = en[g];
    assign bus.bit_stb      = stb[g];
    assign bus.bit_in       = bin[g];
    assign bus.parity_check = pchk[g];
    assign bus.clr_cnt      = clr[g];
    rxd_frame_check #(
      .DATA_W(DWV[g]), .PARITY_MODE(PMV[g]), .STOP_BITS(SBV[g]), .CNT_W(CWV[g])
    ) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
    );
    assign dout[g] = 9'(bus.data_out);
    assign dv[g]   = bus.data_valid;
    assign pe[g]   = bus.parity_error;
    assign fe[g]   = bus.framing_error;
    assign brk[g]  = bus.break_det;
    assign busy[g] = bus.busy;
    assign pcnt[g] = 8'(bus.parity_err_cnt);
    assign fcnt[g] = 8'(bus.framing_err_cnt);
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (dv[i]) got_q.push_back('{k: 2'(i), d: dout[i], pe: pe[i], fe: fe[i], brk: brk[i],
                                   dbl: prev_dv[i], pc: pcnt[i], fc: fcnt[i]});
    end
    prev_dv = dv;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int k, int n);
    repeat (n) begin
      stb[k] = 1'b0;
      bin[k] = 1'($urandom);
      cyc();
    end
    bin[k] = 1'b1;
  endtask

  task automatic tick(int k, logic b, int gmax);
    idle(k, int'($urandom_range(0, gmax)));
    stb[k] = 1'b1;
    bin[k] = b;
    cyc();
    stb[k] = 1'b0;
    bin[k] = 1'b1;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Drives one frame (stop bits st[0] then st[1]) and records what the receiver must report.
  task automatic send_frame(int k, logic [8:0] d, logic p, logic [1:0] st,
                            logic ce, logic cl, int gmax);
    logic [8:0] dm;
    int ones;
    int cmax;
    logic epe, efe, ebrk;
    dm = d & 9'((1 << DWV[k]) - 1);
    pchk[k] = ce;
    tick(k, 1'b0, gmax);
    for (int i = 0; i < DWV[k]; i++) tick(k, dm[i], gmax);
    if (PMV[k] != 0) tick(k, p, gmax);
    if (SBV[k] == 2) tick(k, st[0], gmax);
    idle(k, int'($urandom_range(0, gmax)));
    clr[k] = cl;
    stb[k] = 1'b1;
    bin[k] = st[SBV[k]-1];
    cyc();
    stb[k] = 1'b0;
    bin[k] = 1'b1;
    clr[k] = 1'b0;

    ones = $countones(dm) + ((PMV[k] != 0) ? int'(p) : 0);
    epe  = ce && (((PMV[k] == 1) && (ones % 2 == 1)) || ((PMV[k] == 2) && (ones % 2 == 0)));
    efe  = !st[0] || ((SBV[k] == 2) && !st[1]);
    ebrk = (dm == 0) && ((PMV[k] == 0) || !p) && !st[0] && ((SBV[k] == 1) || !st[1]);
    cmax = (1 << CWV[k]) - 1;
    if (cl) begin
      mp[k] = 0;
      mf[k] = 0;
    end else begin
      if (epe && mp[k] < cmax) mp[k]++;
      if (efe && mf[k] < cmax) mf[k]++;
    end
    last_d[k] = dm;
    exp_q.push_back('{k: 2'(k), d: dm, pe: epe, fe: efe, brk: ebrk, dbl: 1'b0,
                      pc: 8'(mp[k]), fc: 8'(mf[k])});
  endtask

  task automatic check_frames(string tag);
    rec_t e, g;
    repeat (3) cyc();
    total++;
    assert (got_q.size() === exp_q.size()) else begin
      bad++;
      $error("FAIL %s pulses got=%0d expected=%0d", tag, got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        total++;
        assert (g === e) else begin
          bad++;
          $error("FAIL %s frame got k=%0d d=%h pe=%b fe=%b brk=%b dbl=%b pc=%0d fc=%0d expected k=%0d d=%h pe=%b fe=%b brk=%b dbl=%b pc=%0d fc=%0d",
                 tag, g.k, g.d, g.pe, g.fe, g.brk, g.dbl, g.pc, g.fc,
                 e.k, e.d, e.pe, e.fe, e.brk, e.dbl, e.pc, e.fc);
        end
      end
    end
    got_q.delete();
  endtask

  task automatic partial(int k, int nbits);
    tick(k, 1'b0, 0);
    for (int i = 0; i < nbits; i++) tick(k, 1'($urandom), 0);
  endtask

  initial begin
    logic [8:0] rd;
    logic rp;
    logic [1:0] rst_bits;
    int kk;

    reset = 1'b1;
    en = '1; stb = '0; bin = '1; pchk = '1; clr = '0;
    for (int i = 0; i < NI; i++) begin
      mp[i] = 0; mf[i] = 0; last_d[i] = '0;
    end
    repeat (2) cyc();
    for (int i = 0; i < NI; i++)
      chk($sformatf("reset_outputs%0d", i),
          {2'b0, dout[i], dv[i], pe[i], fe[i], brk[i], busy[i], pcnt[i], fcnt[i]}, 32'd0);
    reset = 1'b0;
    cyc();

    // Clean frame, default format.
    send_frame(0, 9'h05A, 1'b0, 2'b11, 1'b1, 1'b0, 1);
    chk("busy_after_last_stop", 32'(busy[0]), 32'd0);
    check_frames("clean_5a");
    chk("dout_5a", 32'(dout[0]), 32'h5A);

    send_frame(0, 9'h05A, 1'b1, 2'b11, 1'b1, 1'b0, 1);
    check_frames("parity_err");
    chk("pcnt_after_perr", 32'(pcnt[0]), 32'd1);
    chk("perr_held", 32'(pe[0]), 32'd1);
    send_frame(0, 9'h05A, 1'b1, 2'b11, 1'b0, 1'b0, 1);
    check_frames("parity_check_off");
    chk("pcnt_unchanged", 32'(pcnt[0]), 32'd1);

    // Odd parity, 7 data bits, two stop bits with the second one bad.
    send_frame(1, 9'h041, 1'b1, 2'b01, 1'b1, 1'b0, 1);
    check_frames("odd_2stop");
    chk("ferr_2stop", 32'(fe[1]), 32'd1);
    chk("fcnt_2stop", 32'(fcnt[1]), 32'd1);

    send_frame(0, 9'h000, 1'b0, 2'b00, 1'b1, 1'b0, 0);
    check_frames("break");
    chk("break_flag", 32'(brk[0]), 32'd1);

    // Narrow counter saturates, then clear wins over a simultaneous increment.
    for (int i = 0; i < 5; i++) begin
      send_frame(2, 9'($urandom), 1'b0, 2'b10, 1'b1, 1'b0, 1);
      check_frames("sat_frame");
      chk($sformatf("fcnt_sat%0d", i), 32'(fcnt[2]), 32'((i + 1 < 3) ? i + 1 : 3));
    end
    send_frame(2, 9'($urandom), 1'b0, 2'b10, 1'b1, 1'b1, 1);
    check_frames("clr_vs_inc");
    chk("fcnt_cleared", 32'(fcnt[2]), 32'd0);

    // rx_en abort after four data bits.
    partial(0, 4);
    chk("busy_mid_frame", 32'(busy[0]), 32'd1);
    en[0] = 1'b0;
    cyc();
    chk("busy_after_disable", 32'(busy[0]), 32'd0);
    chk("dout_held_on_abort", 32'(dout[0]), 32'(last_d[0]));
    en[0] = 1'b1;
    send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b1, 1'b0, 0);
    check_frames("after_en_abort");

    // Reset abort after four data bits clears everything immediately.
    partial(0, 4);
    reset = 1'b1;
    #1;
    chk("busy_async_reset", 32'(busy[0]), 32'd0);
    chk("dout_async_reset", 32'(dout[0]), 32'd0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      mp[i] = 0; mf[i] = 0; last_d[i] = '0;
    end
    cyc();
    send_frame(0, 9'h0A5, 1'b0, 2'b11, 1'b1, 1'b0, 0);
    check_frames("after_reset_abort");

    // Back-to-back frames with strobes on every cycle.
    send_frame(1, 9'h055, 1'b0, 2'b11, 1'b1, 1'b0, 0);
    send_frame(1, 9'h02A, 1'b1, 2'b11, 1'b1, 1'b0, 0);
    check_frames("back_to_back");

    for (int n = 0; n < 60; n++) begin
      kk = int'($urandom_range(0, NI - 1));
      rd = 9'($urandom);
      rp = 1'($urandom);
      rst_bits = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      if ($urandom_range(0, 9) == 0) begin
        rd = '0; rp = 1'b0; rst_bits = 2'b00;
      end
      send_frame(kk, rd, rp, rst_bits, 1'($urandom), ($urandom_range(0, 11) == 0), 2);
      if (n % 4 == 3) check_frames("random");
    end
    check_frames("random_tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
